// File: rtl/param_state_sequencer.sv
// param_state_sequencer: N-state cyclic sequencer with dwell, pause/step, wrap or ping-pong.
// Define SEQ_ONEHOT_EN to add the registered one-hot state output oOneHot.
module param_state_sequencer #(
   parameter int STATE_W    = 2,
   parameter int NUM_STATES = 4,
   parameter int DWELL      = 1,
   parameter int DWELL_W    = 4
) (
   input  logic               iClk,
   input  logic               iRestart,
   input  logic               iPause,
   input  logic               iDir,
   input  logic               iMode,
   input  logic               iStep,
   output logic [STATE_W-1:0] oValorEstado,
   output logic               oWrap,
   output logic               oRunning
`ifdef SEQ_ONEHOT_EN
   ,
   output logic [NUM_STATES-1:0] oOneHot
`endif
);
   typedef enum logic [1:0] {sIdle, sRun, sPaused} ctrlT;
   localparam logic [STATE_W-1:0] LAST  = STATE_W'(NUM_STATES - 1);
   localparam logic [STATE_W-1:0] ONE   = STATE_W'(1);
   localparam logic [DWELL_W-1:0] DLAST = DWELL_W'(DWELL - 1);
   localparam logic [DWELL_W-1:0] DONE  = DWELL_W'(1);
   ctrlT ctrlQ, ctrlD;
   logic [DWELL_W-1:0] cntQ, cntD;
   logic [STATE_W-1:0] valD, valAdv;
   logic dirQ, dirD, ppQ, dirEff, dirStep, inRange, endHit, advance, wrapD;
   always_comb begin
      ctrlD   = iPause ? sPaused : sRun;
      inRange = oValorEstado <= LAST;
      dirEff  = (iMode && ppQ) ? dirQ : iDir;
      // ping-pong endpoints force the only legal direction out of them
      dirStep = !iMode ? dirEff : (oValorEstado == LAST) ? 1'b1 : (oValorEstado == '0) ? 1'b0 : dirEff;
      valAdv  = !inRange ? '0 :
                !iMode ? (dirStep ? ((oValorEstado == '0) ? LAST : oValorEstado - ONE)
                                  : ((oValorEstado == LAST) ? '0 : oValorEstado + ONE)) :
                (dirStep ? oValorEstado - ONE : oValorEstado + ONE);
      endHit  = inRange && (iMode ? (dirStep ? valAdv == '0 : valAdv == LAST)
                                  : (dirStep ? oValorEstado == '0 : oValorEstado == LAST));
      advance = iPause ? iStep : (cntQ == DLAST);
      cntD    = advance ? '0 : iPause ? cntQ : cntQ + DONE;
      valD    = advance ? valAdv : oValorEstado;
      wrapD   = advance && endHit;
      dirD    = (iMode && advance && inRange) ? dirStep ^ endHit : dirEff;
   end
   // ppQ resets high so ping-pong starts upward regardless of iDir
   always_ff @(posedge iClk) begin
      if (iRestart) begin
         ctrlQ        <= sIdle;
         oValorEstado <= '0;
         cntQ         <= '0;
         dirQ         <= 1'b0;
         ppQ          <= 1'b1;
         oWrap        <= 1'b0;
`ifdef SEQ_ONEHOT_EN
         oOneHot      <= NUM_STATES'(1);
`endif
      end else begin
         ctrlQ        <= ctrlD;
         oValorEstado <= valD;
         cntQ         <= cntD;
         dirQ         <= dirD;
         ppQ          <= iMode;
         oWrap        <= wrapD;
`ifdef SEQ_ONEHOT_EN
         oOneHot      <= NUM_STATES'(1) << valD;
`endif
      end
   end
   assign oRunning = (ctrlQ == sRun);
endmodule

// File: tb/tb_param_state_sequencer.sv
// tb_param_state_sequencer: scoreboard bench over three parameterisations of the sequencer.
module tb_param_state_sequencer;
   logic iClk = 1'b0, iRestart = 1'b1, iPause = 1'b0, iDir = 1'b0, iMode = 1'b0, iStep = 1'b0;
   logic [1:0] valA, valC;
   logic [2:0] valB;
   logic wrapA, wrapB, wrapC, runA, runB, runC;
`ifdef SEQ_ONEHOT_EN
   logic [3:0] ohA, ohC;
   logic [4:0] ohB;
`endif
   typedef struct {int v; logic w;} expT;
   expT sb[$];
   expT e;
   int cmpCount = 0, errCount = 0;

   always #5 iClk = ~iClk;

   param_state_sequencer dA (.iClk(iClk), .iRestart(iRestart), .iPause(iPause), .iDir(iDir),
      .iMode(iMode), .iStep(iStep), .oValorEstado(valA), .oWrap(wrapA), .oRunning(runA)
`ifdef SEQ_ONEHOT_EN
      , .oOneHot(ohA)
`endif
   );
   param_state_sequencer #(.STATE_W(3), .NUM_STATES(5), .DWELL(3)) dB (.iClk(iClk),
      .iRestart(iRestart), .iPause(iPause), .iDir(iDir), .iMode(iMode), .iStep(iStep),
      .oValorEstado(valB), .oWrap(wrapB), .oRunning(runB)
`ifdef SEQ_ONEHOT_EN
      , .oOneHot(ohB)
`endif
   );
   param_state_sequencer #(.DWELL(4)) dC (.iClk(iClk), .iRestart(iRestart), .iPause(iPause),
      .iDir(iDir), .iMode(iMode), .iStep(iStep), .oValorEstado(valC), .oWrap(wrapC), .oRunning(runC)
`ifdef SEQ_ONEHOT_EN
      , .oOneHot(ohC)
`endif
   );

   task automatic tick;
      @(posedge iClk);
      #1;
   endtask

   task automatic doRestart(input int n);
      iRestart = 1'b1;
      repeat (n) tick();
      iRestart = 1'b0;
   endtask

   task automatic test_reset;
      iPause = 0; iMode = 0; iDir = 0; iStep = 0;
      doRestart(2);
      cmpCount++;
      if ({valA, wrapA, runA} !== 4'b0) begin
         errCount++;
         $display("FAIL reset A: got val=%0d wrap=%b run=%b, want 0 0 0", valA, wrapA, runA);
      end
      cmpCount++;
      if ({valB, wrapB, runB} !== 5'b0) begin
         errCount++;
         $display("FAIL reset B: got val=%0d wrap=%b run=%b, want 0 0 0", valB, wrapB, runB);
      end
      cmpCount++;
      if ({valC, wrapC, runC} !== 4'b0) begin
         errCount++;
         $display("FAIL reset C: got val=%0d wrap=%b run=%b, want 0 0 0", valC, wrapC, runC);
      end
`ifdef SEQ_ONEHOT_EN
      cmpCount++;
      if (ohA !== 4'b0001 || ohB !== 5'b00001) begin
         errCount++;
         $display("FAIL reset onehot: got A=%b B=%b, want 0001 00001", ohA, ohB);
      end
`endif
   endtask

   task automatic test_default_up;
      int seq[6] = '{1, 2, 3, 0, 1, 2};
      for (int i = 0; i < 6; i++) sb.push_back('{seq[i], seq[i] == 0});
      for (int i = 0; i < 6; i++) begin
         tick();
         e = sb.pop_front();
         cmpCount++;
         if (valA !== 2'(e.v) || wrapA !== e.w || runA !== 1'b1) begin
            errCount++;
            $display("FAIL up[%0d]: got val=%0d wrap=%b run=%b, want val=%0d wrap=%b run=1", i, valA, wrapA, runA, e.v, e.w);
         end
      end
   endtask

   task automatic test_dwell;
      doRestart(1);
      for (int i = 0; i < 30; i++) sb.push_back('{((i + 1) / 3) % 5, ((i + 1) % 15) == 0});
      for (int i = 0; i < 30; i++) begin
         tick();
         e = sb.pop_front();
         cmpCount++;
         if (valB !== 3'(e.v) || wrapB !== e.w) begin
            errCount++;
            $display("FAIL dwell[%0d]: got val=%0d wrap=%b, want val=%0d wrap=%b", i, valB, wrapB, e.v, e.w);
         end
      end
   endtask

   task automatic test_pause_step;
      logic stp[5] = '{1, 0, 1, 0, 1};
      int sv[5] = '{3, 3, 0, 0, 1};
      doRestart(1);
      sb.push_back('{1, 0});
      sb.push_back('{2, 0});
      for (int i = 0; i < 2; i++) begin
         tick();
         e = sb.pop_front();
         cmpCount++;
         if (valA !== 2'(e.v) || wrapA !== e.w) begin
            errCount++;
            $display("FAIL prepause[%0d]: got val=%0d wrap=%b, want val=%0d wrap=%b", i, valA, wrapA, e.v, e.w);
         end
      end
      iPause = 1;
      for (int i = 0; i < 10; i++) sb.push_back('{2, 0});
      for (int i = 0; i < 10; i++) begin
         tick();
         e = sb.pop_front();
         cmpCount++;
         if (valA !== 2'(e.v) || wrapA !== e.w || runA !== 1'b0) begin
            errCount++;
            $display("FAIL pause[%0d]: got val=%0d wrap=%b run=%b, want val=%0d wrap=0 run=0", i, valA, wrapA, runA, e.v);
         end
      end
      for (int i = 0; i < 5; i++) sb.push_back('{sv[i], stp[i] && sv[i] == 0});
      for (int i = 0; i < 5; i++) begin
         iStep = stp[i];
         tick();
         iStep = 0;
         e = sb.pop_front();
         cmpCount++;
         if (valA !== 2'(e.v) || wrapA !== e.w || runA !== 1'b0) begin
            errCount++;
            $display("FAIL step[%0d]: got val=%0d wrap=%b run=%b, want val=%0d wrap=%b run=0", i, valA, wrapA, runA, e.v, e.w);
         end
      end
      iPause = 0;
   endtask

   task automatic test_pingpong;
      int seq[7] = '{1, 2, 3, 2, 1, 0, 1};
      logic wr[7] = '{0, 0, 1, 0, 0, 1, 0};
      iMode = 1; iDir = 1;
      doRestart(1);
      for (int i = 0; i < 7; i++) sb.push_back('{seq[i], wr[i]});
      for (int i = 0; i < 7; i++) begin
         tick();
         iDir = ~iDir;
         e = sb.pop_front();
         cmpCount++;
         if (valA !== 2'(e.v) || wrapA !== e.w) begin
            errCount++;
            $display("FAIL pingpong[%0d]: got val=%0d wrap=%b, want val=%0d wrap=%b", i, valA, wrapA, e.v, e.w);
         end
      end
   endtask

   task automatic test_down;
      int seq[5] = '{3, 2, 1, 0, 3};
      iMode = 0; iDir = 1;
      doRestart(1);
      for (int i = 0; i < 5; i++) sb.push_back('{seq[i], seq[i] == 3});
      for (int i = 0; i < 5; i++) begin
         tick();
         e = sb.pop_front();
         cmpCount++;
         if (valA !== 2'(e.v) || wrapA !== e.w) begin
            errCount++;
            $display("FAIL down[%0d]: got val=%0d wrap=%b, want val=%0d wrap=%b", i, valA, wrapA, e.v, e.w);
         end
      end
   endtask

   task automatic test_restart_mid;
      int seq[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
      iMode = 0; iDir = 0;
      doRestart(1);
      repeat (6) tick();
      cmpCount++;
      if (valC !== 2'd1) begin
         errCount++;
         $display("FAIL middwell: got val=%0d, want 1", valC);
      end
      iRestart = 1;
      tick();
      iRestart = 0;
      cmpCount++;
      if ({valC, wrapC, runC} !== 4'b0) begin
         errCount++;
         $display("FAIL midrestart: got val=%0d wrap=%b run=%b, want 0 0 0", valC, wrapC, runC);
      end
      for (int i = 0; i < 8; i++) sb.push_back('{seq[i], 0});
      for (int i = 0; i < 8; i++) begin
         tick();
         e = sb.pop_front();
         cmpCount++;
         if (valC !== 2'(e.v) || wrapC !== e.w) begin
            errCount++;
            $display("FAIL release[%0d]: got val=%0d wrap=%b, want val=%0d wrap=0", i, valC, wrapC, e.v);
         end
`ifdef SEQ_ONEHOT_EN
         cmpCount++;
         if (ohC !== 4'b0001 << e.v) begin
            errCount++;
            $display("FAIL onehot[%0d]: got %b, want state %0d set", i, ohC, e.v);
         end
`endif
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_default_up();
      test_dwell();
      test_pause_step();
      test_pingpong();
      test_down();
      test_restart_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end
endmodule
